// File: rtl/share_config_hub.sv
// Shared configuration register hub: decodes the byte-wide config write bus into
// double-buffered device config ports, sync pulses, buzzer, LEDs and a read-back mux.
// Build option: SHARE_CFG_OVF_EN keeps overflowing commits out and records sticky OVF flags.
//
// Device port handshake: a word transfers on any edge where DEV_CFG_VALID[d] and
// DEV_CFG_READY[d] are both 1; while VALID=1 and READY=0, DEV_CFG_DATA and VALID
// hold steady, except that with SHARE_CFG_OVF_EN undefined an overflowing commit
// replaces the pending word.
module share_config_hub #(
  parameter int NUM_DEV  = 3,
  parameter int BYTES    = 3,
  parameter int SYNC_CH  = 2,
  parameter int SYNC_LEN = 4,
  parameter int BUZ_TICK = 1000
) (
  input  logic                       CLK_LOW,
  input  logic                       RST_N,
  input  logic [2:0]                 HW_REV,
  input  logic                       SHARE_CONFIG_WE,
  input  logic [7:0]                 SHARE_CONFIG_ADDR,
  input  logic [7:0]                 SHARE_CONFIG_DATA,
  input  logic [7:0]                 READ_REG_ADDR,
  output logic [7:0]                 READ_BACK_DATA,
  input  logic [7:0]                 KEY_VALUE,
  input  logic                       INPUT_CLK_VALID,
  input  logic [SYNC_CH-1:0]         LOAD_PROTECT,
  output logic [SYNC_CH-1:0]         CH_SYNC_N,
  output logic [4:0]                 LED_DATA,
  output logic                       BUZZER_SEL,
  output logic                       BUZZER_EN,
  output logic [NUM_DEV*8*BYTES-1:0] DEV_CFG_DATA,
  output logic [NUM_DEV-1:0]         DEV_CFG_VALID,
  input  logic [NUM_DEV-1:0]         DEV_CFG_READY
);

  localparam int W  = 8 * BYTES;
  localparam int CW = $clog2(SYNC_LEN + 1);
  localparam int TW = 8 + $clog2(BUZ_TICK);

  localparam logic [7:0] ADDR_SYNC    = 8'h04;
  localparam logic [7:0] ADDR_LED     = 8'h0A;
  localparam logic [7:0] ADDR_BUZ_SEL = 8'h30;
  localparam logic [7:0] ADDR_BUZ_DUR = 8'h31;
  localparam logic [7:0] ADDR_OVF     = 8'hC9;

  logic [W-1:0]       asm_q    [NUM_DEV];
  logic [W-1:0]       hold_q   [NUM_DEV];
  logic [W-1:0]       merged   [NUM_DEV];
  logic [NUM_DEV-1:0] valid_q;
  logic [NUM_DEV-1:0] commit;
  logic [NUM_DEV-1:0] ovf_bits;
  logic [CW-1:0]      sync_cnt [SYNC_CH];
  logic [TW-1:0]      buz_timer;

  // The committing byte is merged here so the hold register takes the full word in one edge.
  always_comb begin
    for (int d = 0; d < NUM_DEV; d++) begin
      commit[d] = SHARE_CONFIG_WE && (SHARE_CONFIG_ADDR == 8'(16 + 4 * d + BYTES - 1));
      merged[d] = asm_q[d];
      merged[d][8*(BYTES-1) +: 8] = SHARE_CONFIG_DATA;
    end
  end

  always_ff @(posedge CLK_LOW or negedge RST_N) begin
    if (!RST_N) begin
      valid_q <= '0;
      for (int d = 0; d < NUM_DEV; d++) begin
        asm_q[d]  <= '0;
        hold_q[d] <= '0;
      end
    end else begin
      for (int d = 0; d < NUM_DEV; d++) begin
        for (int b = 0; b < BYTES; b++) begin
          if (SHARE_CONFIG_WE && (SHARE_CONFIG_ADDR == 8'(16 + 4 * d + b)))
            asm_q[d][8*b +: 8] <= SHARE_CONFIG_DATA;
        end
        if (commit[d]) begin
          if (!valid_q[d] || DEV_CFG_READY[d]) begin
            hold_q[d]  <= merged[d];
            valid_q[d] <= 1'b1;
          end else begin
`ifdef SHARE_CFG_OVF_EN
            hold_q[d] <= hold_q[d];
`else
            hold_q[d] <= merged[d];
`endif
          end
        end else if (valid_q[d] && DEV_CFG_READY[d]) begin
          valid_q[d] <= 1'b0;
        end
      end
    end
  end

`ifdef SHARE_CFG_OVF_EN
  logic [NUM_DEV-1:0] ovf_q;
  logic [NUM_DEV-1:0] ovf_set;
  logic [NUM_DEV-1:0] ovf_clr;

  assign ovf_set = commit & valid_q & ~DEV_CFG_READY;
  assign ovf_clr = (SHARE_CONFIG_WE && SHARE_CONFIG_ADDR == ADDR_OVF) ?
                   SHARE_CONFIG_DATA[NUM_DEV-1:0] : '0;

  // A new overflow wins over a clear on the same edge.
  always_ff @(posedge CLK_LOW or negedge RST_N) begin
    if (!RST_N) ovf_q <= '0;
    else        ovf_q <= (ovf_q & ~ovf_clr) | ovf_set;
  end
  assign ovf_bits = ovf_q;
`else
  assign ovf_bits = '0;
`endif

  always_comb begin
    DEV_CFG_DATA = '0;
    for (int d = 0; d < NUM_DEV; d++) DEV_CFG_DATA[d*W +: W] = hold_q[d];
  end
  assign DEV_CFG_VALID = valid_q;

  always_ff @(posedge CLK_LOW or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < SYNC_CH; i++) sync_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < SYNC_CH; i++) begin
        if (SHARE_CONFIG_WE && SHARE_CONFIG_ADDR == ADDR_SYNC && SHARE_CONFIG_DATA[i])
          sync_cnt[i] <= CW'(SYNC_LEN);
        else if (sync_cnt[i] != '0)
          sync_cnt[i] <= sync_cnt[i] - CW'(1);
      end
    end
  end

  always_comb begin
    CH_SYNC_N = '1;
    for (int i = 0; i < SYNC_CH; i++) CH_SYNC_N[i] = (sync_cnt[i] == '0);
  end

  always_ff @(posedge CLK_LOW or negedge RST_N) begin
    if (!RST_N) begin
      LED_DATA   <= '0;
      BUZZER_SEL <= 1'b0;
      buz_timer  <= '0;
    end else begin
      if (SHARE_CONFIG_WE && SHARE_CONFIG_ADDR == ADDR_LED)
        LED_DATA <= SHARE_CONFIG_DATA[4:0];
      if (SHARE_CONFIG_WE && SHARE_CONFIG_ADDR == ADDR_BUZ_SEL)
        BUZZER_SEL <= SHARE_CONFIG_DATA[0];
      if (SHARE_CONFIG_WE && SHARE_CONFIG_ADDR == ADDR_BUZ_DUR)
        buz_timer <= TW'(SHARE_CONFIG_DATA) * TW'(BUZ_TICK);
      else if (buz_timer != '0)
        buz_timer <= buz_timer - TW'(1);
    end
  end
  assign BUZZER_EN = (buz_timer != '0);

  always_ff @(posedge CLK_LOW or negedge RST_N) begin
    if (!RST_N) begin
      READ_BACK_DATA <= '0;
    end else begin
      case (READ_REG_ADDR)
        8'hB0:   READ_BACK_DATA <= KEY_VALUE;
        8'hB1:   READ_BACK_DATA <= {8{INPUT_CLK_VALID}};
        8'hC0:   READ_BACK_DATA <= {5'b0, HW_REV};
        8'hC4:   READ_BACK_DATA <= 8'(LOAD_PROTECT);
        8'hC8:   READ_BACK_DATA <= 8'(valid_q);
        ADDR_OVF: READ_BACK_DATA <= 8'(ovf_bits);
        default: READ_BACK_DATA <= READ_BACK_DATA;
      endcase
    end
  end

endmodule

// File: tb/tb_share_config_hub.sv
// Self-checking bench for share_config_hub: read-back vector table, device word
// scoreboard, and hand-written sequences for sync, buzzer, overflow and reset.
module tb_share_config_hub;

  localparam int NUM_DEV  = 3;
  localparam int BYTES    = 3;
  localparam int SYNC_CH  = 2;
  localparam int SYNC_LEN = 4;
  localparam int BUZ_TICK = 10;
  localparam int W        = 8 * BYTES;
  localparam int SW       = 3 + W;

  logic                       clk;
  logic                       rst_n;
  logic [2:0]                 hw_rev;
  logic                       we;
  logic [7:0]                 addr;
  logic [7:0]                 data;
  logic [7:0]                 rd_addr;
  logic [7:0]                 rb_data;
  logic [7:0]                 key;
  logic                       clk_valid;
  logic [SYNC_CH-1:0]         load_protect;
  logic [SYNC_CH-1:0]         sync_n;
  logic [4:0]                 led;
  logic                       buz_sel;
  logic                       buz_en;
  logic [NUM_DEV*W-1:0]       dev_data;
  logic [NUM_DEV-1:0]         dev_valid;
  logic [NUM_DEV-1:0]         dev_ready;

  int checks = 0;
  int errors = 0;
  logic [SW-1:0] exp_q[$];

  share_config_hub #(
    .NUM_DEV(NUM_DEV), .BYTES(BYTES), .SYNC_CH(SYNC_CH),
    .SYNC_LEN(SYNC_LEN), .BUZ_TICK(BUZ_TICK)
  ) dut (
    .CLK_LOW(clk), .RST_N(rst_n), .HW_REV(hw_rev),
    .SHARE_CONFIG_WE(we), .SHARE_CONFIG_ADDR(addr), .SHARE_CONFIG_DATA(data),
    .READ_REG_ADDR(rd_addr), .READ_BACK_DATA(rb_data),
    .KEY_VALUE(key), .INPUT_CLK_VALID(clk_valid), .LOAD_PROTECT(load_protect),
    .CH_SYNC_N(sync_n), .LED_DATA(led), .BUZZER_SEL(buz_sel), .BUZZER_EN(buz_en),
    .DEV_CFG_DATA(dev_data), .DEV_CFG_VALID(dev_valid), .DEV_CFG_READY(dev_ready)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Driver tasks: inputs change 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_reg(input logic [7:0] a, input logic [7:0] d);
    we = 1'b1;
    addr = a;
    data = d;
    tick();
    we = 1'b0;
  endtask

  task automatic read_reg(input string name, input logic [7:0] a, input logic [7:0] exp);
    rd_addr = a;
    tick();
    chk(name, 32'(rb_data), 32'(exp));
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_valid"}, 32'(dev_valid), 0);
    chk({tag, "_data"}, 32'(dev_data), 0);
    chk({tag, "_sync"}, 32'(sync_n), 32'h3);
    chk({tag, "_led"}, 32'(led), 0);
    chk({tag, "_buz_en"}, 32'(buz_en), 0);
    chk({tag, "_buz_sel"}, 32'(buz_sel), 0);
    chk({tag, "_rb"}, 32'(rb_data), 0);
  endtask

  // Scoreboard: a transfer is decided by VALID&READY seen at the falling edge.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int d = 0; d < NUM_DEV; d++) begin
        if (dev_valid[d] && dev_ready[d]) begin
          if (exp_q.size() == 0) begin
            chk("xfer_unexpected", 32'({3'(d), dev_data[d*W +: W]}), 32'hFFFF_FFFF);
          end else begin
            logic [SW-1:0] e;
            e = exp_q.pop_front();
            chk("xfer_word", 32'({3'(d), dev_data[d*W +: W]}), 32'(e));
          end
        end
      end
    end
  end

  typedef struct {
    logic [7:0] addr;
    logic [7:0] key;
    logic       clk_valid;
    logic [1:0] lp;
    logic [2:0] hw;
    logic [7:0] exp;
  } rb_vec_t;

  rb_vec_t tbl[8];

  initial begin
    int cnt;
    logic [1:0] exp_sync;
    logic [W-1:0] exp_word;
    logic [7:0] exp_ovf;

    tbl[0] = '{8'hB0, 8'hA5, 1'b0, 2'b00, 3'd0, 8'hA5};
    tbl[1] = '{8'hB1, 8'h00, 1'b1, 2'b00, 3'd0, 8'hFF};
    tbl[2] = '{8'hB1, 8'h00, 1'b0, 2'b00, 3'd0, 8'h00};
    tbl[3] = '{8'hC0, 8'h00, 1'b0, 2'b00, 3'd5, 8'h05};
    tbl[4] = '{8'hC4, 8'h00, 1'b0, 2'b10, 3'd0, 8'h02};
    tbl[5] = '{8'h77, 8'h3C, 1'b1, 2'b01, 3'd7, 8'h02};
    tbl[6] = '{8'hC4, 8'h00, 1'b0, 2'b01, 3'd0, 8'h01};
    tbl[7] = '{8'hC8, 8'h00, 1'b0, 2'b00, 3'd0, 8'h00};

    rst_n = 1'b0; hw_rev = '0; we = 1'b0; addr = '0; data = '0; rd_addr = '0;
    key = '0; clk_valid = 1'b0; load_protect = '0; dev_ready = '1;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Basic commit with READY held high: word visible one edge later, then taken.
    write_reg(8'h10, 8'h11);
    write_reg(8'h11, 8'h22);
    exp_q.push_back({3'd0, 24'h332211});
    write_reg(8'h12, 8'h33);
    chk("t1_valid", 32'(dev_valid[0]), 1);
    chk("t1_word", 32'(dev_data[0*W +: W]), 32'h332211);
    tick();
    chk("t1_valid_clear", 32'(dev_valid[0]), 0);

    // Overflow on a stalled port.
    dev_ready[1] = 1'b0;
    write_reg(8'h14, 8'h0C);
    write_reg(8'h15, 8'h0B);
    write_reg(8'h16, 8'h0A);
    write_reg(8'h14, 8'h0F);
    write_reg(8'h15, 8'h0E);
    write_reg(8'h16, 8'h0D);
`ifdef SHARE_CFG_OVF_EN
    exp_word = 24'h0A0B0C;
    exp_ovf = 8'h02;
`else
    exp_word = 24'h0D0E0F;
    exp_ovf = 8'h00;
`endif
    chk("ovf_stable_valid", 32'(dev_valid[1]), 1);
    chk("ovf_hold_word", 32'(dev_data[1*W +: W]), 32'(exp_word));
    read_reg("ovf_flags", 8'hC9, exp_ovf);
    write_reg(8'hC9, 8'h02);
    tick();
    chk("ovf_cleared", 32'(rb_data), 0);
    exp_q.push_back({3'd1, exp_word});
    dev_ready[1] = 1'b1;
    tick();
    chk("ovf_drained", 32'(dev_valid[1]), 0);

    // Commit landing on the same edge as a transfer.
    write_reg(8'h18, 8'h01);
    write_reg(8'h19, 8'h02);
    exp_q.push_back({3'd2, 24'h030201});
    write_reg(8'h1A, 8'h03);
    exp_q.push_back({3'd2, 24'h550201});
    write_reg(8'h1A, 8'h55);
    chk("same_edge_valid", 32'(dev_valid[2]), 1);
    chk("same_edge_word", 32'(dev_data[2*W +: W]), 32'h550201);
    read_reg("same_edge_no_ovf", 8'hC9, 8'h00);
    chk("same_edge_drained", 32'(dev_valid[2]), 0);

    // Read-back vector table.
    for (int i = 0; i < 8; i++) begin
      rd_addr = tbl[i].addr;
      key = tbl[i].key;
      clk_valid = tbl[i].clk_valid;
      load_protect = tbl[i].lp;
      hw_rev = tbl[i].hw;
      tick();
      chk($sformatf("rb_vec%0d", i), 32'(rb_data), 32'(tbl[i].exp));
    end

    write_reg(8'h0A, 8'hF5);
    chk("led", 32'(led), 32'h15);
    write_reg(8'h0B, 8'hFF);
    chk("led_unlisted", 32'(led), 32'h15);

    // Sync pulse: SYNC_LEN cycles low after the write edge.
    write_reg(8'h04, 8'h03);
    for (int i = 0; i < 6; i++) begin
      exp_sync = (i < SYNC_LEN) ? 2'b00 : 2'b11;
      chk($sformatf("sync_c%0d", i), 32'(sync_n), 32'(exp_sync));
      tick();
    end

    // Rewrite of channel 0 two cycles in restarts only that channel.
    write_reg(8'h04, 8'h03);
    for (int i = 0; i < 8; i++) begin
      exp_sync = {(i >= 4), (i >= 6)};
      chk($sformatf("sync_rw_c%0d", i), 32'(sync_n), 32'(exp_sync));
      if (i == 1) begin
        we = 1'b1; addr = 8'h04; data = 8'h01;
      end else begin
        we = 1'b0;
      end
      tick();
    end
    we = 1'b0;

    // Buzzer duration and early stop.
    write_reg(8'h30, 8'h01);
    chk("buz_sel", 32'(buz_sel), 1);
    write_reg(8'h31, 8'h03);
    cnt = 0;
    while (buz_en && cnt < 100) begin
      cnt++;
      tick();
    end
    chk("buz_len", 32'(cnt), 32'(3 * BUZ_TICK));
    write_reg(8'h31, 8'h03);
    repeat (5) tick();
    chk("buz_mid_on", 32'(buz_en), 1);
    write_reg(8'h31, 8'h00);
    chk("buz_stop", 32'(buz_en), 0);

    // Reset in the middle of activity.
    dev_ready[0] = 1'b0;
    write_reg(8'h10, 8'h01);
    write_reg(8'h11, 8'h02);
    write_reg(8'h12, 8'h03);
    write_reg(8'h04, 8'h03);
    write_reg(8'h31, 8'h05);
    key = 8'hAA;
    rd_addr = 8'hB0;
    write_reg(8'h10, 8'h44);
    chk("pre_reset_valid", 32'(dev_valid[0]), 1);
    chk("pre_reset_rb", 32'(rb_data), 32'hAA);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("mid_reset");
    @(negedge clk);
    rst_n = 1'b1;
    rd_addr = 8'h00;
    tick();
    write_reg(8'h12, 8'h77);
    chk("post_reset_word", 32'(dev_data[0*W +: W]), 32'h770000);
    exp_q.push_back({3'd0, 24'h770000});
    dev_ready[0] = 1'b1;
    tick();
    chk("post_reset_drained", 32'(dev_valid[0]), 0);

    tick();
    chk("scoreboard_empty", 32'(exp_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
